// File: rtl/req_gnt_window_checker.sv
// req_gnt_window_checker: multi-channel req/gnt latency window monitor.
// Tracks per-channel request ages and flags grants outside MIN..MAX.
module req_gnt_window_checker #(
  parameter int NUM_CH  = 4,
  parameter int MIN_LAT = 1,
  parameter int MAX_LAT = 2,
  parameter int CNT_W   = 16,
  localparam int CHW    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en_i,
  input  logic              clr_i,
  input  logic              mode_i,
  input  logic [NUM_CH-1:0] req_i,
  input  logic [NUM_CH-1:0] gnt_i,
  output logic [NUM_CH-1:0] pass_o,
  output logic [NUM_CH-1:0] fail_o,
  output logic [NUM_CH-1:0] err_sticky_o,
  output logic [CNT_W-1:0]  pass_cnt_o,
  output logic [CNT_W-1:0]  fail_cnt_o,
  output logic              first_fail_vld_o,
  output logic [CHW-1:0]    first_fail_ch_o
);

  localparam int SW   = $clog2(NUM_CH * MAX_LAT + 1);
  localparam int SUMW = ((CNT_W > SW) ? CNT_W : SW) + 1;

  if (MIN_LAT < 1 || MAX_LAT < MIN_LAT || NUM_CH < 1) begin : g_param_chk
    $error("req_gnt_window_checker: illegal parameters");
  end

  // bit k-1 of pend holds an attempt of age k
  logic [NUM_CH-1:0][MAX_LAT-1:0] pend_q, pend_d;
  logic [NUM_CH-1:0][MAX_LAT-1:0] keep;
  logic [NUM_CH-1:0] pass_q, pass_d;
  logic [NUM_CH-1:0] fail_q, fail_d;
  logic [NUM_CH-1:0] err_q, err_d;
  logic [CNT_W-1:0]  pcnt_q, pcnt_d;
  logic [CNT_W-1:0]  fcnt_q, fcnt_d;
  logic              ffv_q, ffv_d;
  logic [CHW-1:0]    ffc_q, ffc_d;
  logic [SW-1:0]     pass_n, fail_n;
  logic [CHW-1:0]    low_fail;
  logic [SUMW-1:0]   psum, fsum;

  // Resolve every pending entry against this edge's grant and age the rest
  always_comb begin
    keep   = '0;
    pass_d = '0;
    fail_d = '0;
    pass_n = '0;
    fail_n = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      for (int k = 0; k < MAX_LAT; k++) begin
        if (pend_q[c][k]) begin
          if (gnt_i[c] && (k + 1) >= MIN_LAT) begin
            pass_d[c] = 1'b1;
            pass_n    = pass_n + SW'(1);
          end else if ((k + 1) == MAX_LAT) begin
            fail_d[c] = 1'b1;
            fail_n    = fail_n + SW'(1);
          end else if (mode_i && gnt_i[c]) begin
            fail_d[c] = 1'b1;
            fail_n    = fail_n + SW'(1);
          end else begin
            keep[c][k] = 1'b1;
          end
        end
      end
      pend_d[c] = (keep[c] << 1) | MAX_LAT'(en_i & req_i[c]);
    end
  end

  // Saturating counters, sticky flags and first-failure capture
  always_comb begin
    low_fail = '0;
    for (int c = NUM_CH - 1; c >= 0; c--) begin
      if (fail_d[c]) low_fail = CHW'(c);
    end
    psum   = SUMW'(pcnt_q) + SUMW'(pass_n);
    fsum   = SUMW'(fcnt_q) + SUMW'(fail_n);
    pcnt_d = (psum[SUMW-1:CNT_W] != '0) ? '1 : psum[CNT_W-1:0];
    fcnt_d = (fsum[SUMW-1:CNT_W] != '0) ? '1 : fsum[CNT_W-1:0];
    err_d  = err_q | fail_d;
    ffv_d  = ffv_q;
    ffc_d  = ffc_q;
    if (!ffv_q && (|fail_d)) begin
      ffv_d = 1'b1;
      ffc_d = low_fail;
    end
  end

  // State register; clear behaves exactly like reset
  always_ff @(posedge clk) begin
    if (!rst_n || clr_i) begin
      pend_q <= '0;
      pass_q <= '0;
      fail_q <= '0;
      err_q  <= '0;
      pcnt_q <= '0;
      fcnt_q <= '0;
      ffv_q  <= 1'b0;
      ffc_q  <= '0;
    end else begin
      pend_q <= pend_d;
      pass_q <= pass_d;
      fail_q <= fail_d;
      err_q  <= err_d;
      pcnt_q <= pcnt_d;
      fcnt_q <= fcnt_d;
      ffv_q  <= ffv_d;
      ffc_q  <= ffc_d;
    end
  end

  assign pass_o           = pass_q;
  assign fail_o           = fail_q;
  assign err_sticky_o     = err_q;
  assign pass_cnt_o       = pcnt_q;
  assign fail_cnt_o       = fcnt_q;
  assign first_fail_vld_o = ffv_q;
  assign first_fail_ch_o  = ffc_q;

endmodule

// File: tb/tb_req_gnt_window_checker.sv
// tb_req_gnt_window_checker: directed checks of the req/gnt window monitor.
// Three instances share stimulus: defaults, MIN=2/MAX=3, and CNT_W=2.
module tb_req_gnt_window_checker;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b0;
  logic       clr = 1'b0;
  logic       mode = 1'b0;
  logic [3:0] req = '0;
  logic [3:0] gnt = '0;

  logic [3:0]  a_pass, a_fail, a_err;
  logic [15:0] a_pcnt, a_fcnt;
  logic        a_ffv;
  logic [1:0]  a_ffc;
  logic [3:0]  b_pass, b_fail, b_err;
  logic [15:0] b_pcnt, b_fcnt;
  logic        b_ffv;
  logic [1:0]  b_ffc;
  logic [3:0]  c_pass, c_fail, c_err;
  logic [1:0]  c_pcnt, c_fcnt;
  logic        c_ffv;
  logic [1:0]  c_ffc;

  int chk = 0;
  int fails = 0;

  always #5 clk = ~clk;

  req_gnt_window_checker dut_a (
    .clk(clk), .rst_n(rst_n), .en_i(en), .clr_i(clr), .mode_i(mode),
    .req_i(req), .gnt_i(gnt), .pass_o(a_pass), .fail_o(a_fail),
    .err_sticky_o(a_err), .pass_cnt_o(a_pcnt), .fail_cnt_o(a_fcnt),
    .first_fail_vld_o(a_ffv), .first_fail_ch_o(a_ffc)
  );

  req_gnt_window_checker #(.MIN_LAT(2), .MAX_LAT(3)) dut_b (
    .clk(clk), .rst_n(rst_n), .en_i(en), .clr_i(clr), .mode_i(mode),
    .req_i(req), .gnt_i(gnt), .pass_o(b_pass), .fail_o(b_fail),
    .err_sticky_o(b_err), .pass_cnt_o(b_pcnt), .fail_cnt_o(b_fcnt),
    .first_fail_vld_o(b_ffv), .first_fail_ch_o(b_ffc)
  );

  req_gnt_window_checker #(.CNT_W(2)) dut_c (
    .clk(clk), .rst_n(rst_n), .en_i(en), .clr_i(clr), .mode_i(mode),
    .req_i(req), .gnt_i(gnt), .pass_o(c_pass), .fail_o(c_fail),
    .err_sticky_o(c_err), .pass_cnt_o(c_pcnt), .fail_cnt_o(c_fcnt),
    .first_fail_vld_o(c_ffv), .first_fail_ch_o(c_ffc)
  );

  task automatic cyc(input logic e, input logic m,
                     input logic [3:0] r, input logic [3:0] g,
                     input logic cl = 1'b0, input logic rn = 1'b1);
    @(negedge clk);
    en = e; mode = m; req = r; gnt = g; clr = cl; rst_n = rn;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    cyc(1'b0, 1'b0, 4'b0, 4'b0, 1'b0, 1'b0);
  endtask

  task automatic test_reset();
    cyc(1'b1, 1'b0, 4'b1111, 4'b0000);
    cyc(1'b1, 1'b0, 4'b0000, 4'b0000);
    do_reset();
    chk++;
    if ({a_pass, a_fail, a_err} !== 12'h0) begin
      fails++;
      $display("FAIL reset_vec got=%h exp=000", {a_pass, a_fail, a_err});
    end
    chk++;
    if ({a_pcnt, a_fcnt, a_ffv, a_ffc} !== 35'h0) begin
      fails++;
      $display("FAIL reset_cnt got=%h exp=0", {a_pcnt, a_fcnt, a_ffv, a_ffc});
    end
    cyc(1'b0, 1'b0, 4'b0, 4'b0);
    chk++;
    if (a_fail !== 4'b0) begin
      fails++;
      $display("FAIL reset_nofail got=%b exp=0000", a_fail);
    end
  endtask

  task automatic test_pass();
    do_reset();
    cyc(1'b1, 1'b0, 4'b0000, 4'b0000);
    cyc(1'b1, 1'b0, 4'b0000, 4'b0000);
    cyc(1'b1, 1'b0, 4'b0000, 4'b0000);
    cyc(1'b1, 1'b0, 4'b0001, 4'b0000);
    cyc(1'b1, 1'b0, 4'b0000, 4'b0000);
    chk++;
    if (a_pass !== 4'b0000) begin
      fails++;
      $display("FAIL pass_early got=%b exp=0000", a_pass);
    end
    cyc(1'b1, 1'b0, 4'b0000, 4'b0001);
    chk++;
    if (a_pass !== 4'b0001 || a_fail !== 4'b0000) begin
      fails++;
      $display("FAIL pass_pulse got=%b/%b exp=0001/0000", a_pass, a_fail);
    end
    chk++;
    if (a_pcnt !== 16'd1 || a_fcnt !== 16'd0) begin
      fails++;
      $display("FAIL pass_cnt got=%0d/%0d exp=1/0", a_pcnt, a_fcnt);
    end
    cyc(1'b1, 1'b0, 4'b0000, 4'b0000);
    chk++;
    if (a_pass !== 4'b0000 || a_pcnt !== 16'd1) begin
      fails++;
      $display("FAIL pass_1cyc got=%b cnt=%0d exp=0000 cnt=1", a_pass, a_pcnt);
    end
  endtask

  task automatic test_fail();
    do_reset();
    cyc(1'b1, 1'b0, 4'b0000, 4'b0000);
    cyc(1'b1, 1'b0, 4'b0000, 4'b0000);
    cyc(1'b1, 1'b0, 4'b0000, 4'b0000);
    cyc(1'b1, 1'b0, 4'b0010, 4'b0000);
    cyc(1'b1, 1'b0, 4'b0000, 4'b0000);
    chk++;
    if (a_fail !== 4'b0000) begin
      fails++;
      $display("FAIL fail_early got=%b exp=0000", a_fail);
    end
    cyc(1'b1, 1'b0, 4'b0000, 4'b0000);
    chk++;
    if (a_fail !== 4'b0010 || a_err !== 4'b0010) begin
      fails++;
      $display("FAIL fail_pulse got=%b err=%b exp=0010", a_fail, a_err);
    end
    chk++;
    if (a_ffv !== 1'b1 || a_ffc !== 2'd1 || a_fcnt !== 16'd1) begin
      fails++;
      $display("FAIL fail_first got=%b/%0d/%0d exp=1/1/1", a_ffv, a_ffc, a_fcnt);
    end
    cyc(1'b1, 1'b0, 4'b0000, 4'b0000);
    chk++;
    if (a_fail !== 4'b0000 || a_err !== 4'b0010) begin
      fails++;
      $display("FAIL fail_sticky got=%b err=%b exp=0000/0010", a_fail, a_err);
    end
  endtask

  task automatic test_early();
    do_reset();
    cyc(1'b1, 1'b1, 4'b0100, 4'b0000);
    cyc(1'b1, 1'b1, 4'b0000, 4'b0100);
    chk++;
    if (b_fail !== 4'b0100 || b_pass !== 4'b0000) begin
      fails++;
      $display("FAIL early_fail got=%b/%b exp=0100/0000", b_fail, b_pass);
    end
    do_reset();
    cyc(1'b1, 1'b0, 4'b0100, 4'b0000);
    cyc(1'b1, 1'b0, 4'b0000, 4'b0100);
    chk++;
    if (b_fail !== 4'b0000 || b_pass !== 4'b0000) begin
      fails++;
      $display("FAIL early_ignored got=%b/%b exp=0000/0000", b_fail, b_pass);
    end
    cyc(1'b1, 1'b0, 4'b0000, 4'b0100);
    chk++;
    if (b_pass !== 4'b0100 || b_pcnt !== 16'd1 || b_fcnt !== 16'd0) begin
      fails++;
      $display("FAIL early_pass got=%b/%0d/%0d exp=0100/1/0", b_pass, b_pcnt, b_fcnt);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    cyc(1'b1, 1'b0, 4'b0001, 4'b0000);
    cyc(1'b1, 1'b0, 4'b0001, 4'b0000);
    cyc(1'b1, 1'b0, 4'b0001, 4'b0001);
    chk++;
    if (a_pass !== 4'b0001 || a_pcnt !== 16'd2) begin
      fails++;
      $display("FAIL b2b_pass got=%b cnt=%0d exp=0001 cnt=2", a_pass, a_pcnt);
    end
    cyc(1'b1, 1'b0, 4'b0000, 4'b0000);
    chk++;
    if (a_fail !== 4'b0000 || a_pass !== 4'b0000) begin
      fails++;
      $display("FAIL b2b_mid got=%b/%b exp=0000/0000", a_fail, a_pass);
    end
    cyc(1'b1, 1'b0, 4'b0000, 4'b0000);
    chk++;
    if (a_fail !== 4'b0001 || a_fcnt !== 16'd1 || a_pcnt !== 16'd2) begin
      fails++;
      $display("FAIL b2b_fail got=%b/%0d/%0d exp=0001/1/2", a_fail, a_fcnt, a_pcnt);
    end
  endtask

  task automatic test_en();
    do_reset();
    cyc(1'b1, 1'b0, 4'b0001, 4'b0000);
    cyc(1'b0, 1'b0, 4'b0001, 4'b0000);
    cyc(1'b0, 1'b0, 4'b0001, 4'b0000);
    chk++;
    if (a_fail !== 4'b0001 || a_fcnt !== 16'd1) begin
      fails++;
      $display("FAIL en_resolve got=%b cnt=%0d exp=0001 cnt=1", a_fail, a_fcnt);
    end
    cyc(1'b0, 1'b0, 4'b0000, 4'b0000);
    cyc(1'b0, 1'b0, 4'b0000, 4'b0000);
    chk++;
    if (a_fail !== 4'b0000 || a_fcnt !== 16'd1) begin
      fails++;
      $display("FAIL en_nolaunch got=%b cnt=%0d exp=0000 cnt=1", a_fail, a_fcnt);
    end
  endtask

  task automatic test_first_fail();
    do_reset();
    cyc(1'b1, 1'b0, 4'b1010, 4'b0000);
    cyc(1'b1, 1'b0, 4'b0000, 4'b0000);
    cyc(1'b1, 1'b0, 4'b0000, 4'b0000);
    chk++;
    if (a_fail !== 4'b1010 || a_ffc !== 2'd1 || a_fcnt !== 16'd2) begin
      fails++;
      $display("FAIL ff_multi got=%b ch=%0d cnt=%0d exp=1010 ch=1 cnt=2", a_fail, a_ffc, a_fcnt);
    end
    chk++;
    if (c_fcnt !== 2'd2) begin
      fails++;
      $display("FAIL sat_two got=%0d exp=2", c_fcnt);
    end
    cyc(1'b1, 1'b0, 4'b0001, 4'b0000);
    cyc(1'b1, 1'b0, 4'b0000, 4'b0000);
    cyc(1'b1, 1'b0, 4'b0000, 4'b0000);
    chk++;
    if (a_fail !== 4'b0001 || a_ffv !== 1'b1 || a_ffc !== 2'd1) begin
      fails++;
      $display("FAIL ff_frozen got=%b vld=%b ch=%0d exp=0001 vld=1 ch=1", a_fail, a_ffv, a_ffc);
    end
    chk++;
    if (a_err !== 4'b1011 || c_fcnt !== 2'd3) begin
      fails++;
      $display("FAIL ff_sticky err=%b sat=%0d exp=1011 sat=3", a_err, c_fcnt);
    end
    cyc(1'b1, 1'b0, 4'b0110, 4'b0000);
    cyc(1'b1, 1'b0, 4'b0000, 4'b0000);
    cyc(1'b1, 1'b0, 4'b0000, 4'b0000);
    chk++;
    if (c_fcnt !== 2'd3 || a_fcnt !== 16'd5) begin
      fails++;
      $display("FAIL sat_hold got=%0d/%0d exp=3/5", c_fcnt, a_fcnt);
    end
  endtask

  task automatic test_clear(input logic use_rst);
    do_reset();
    cyc(1'b1, 1'b0, 4'b0010, 4'b0000);
    cyc(1'b1, 1'b0, 4'b0000, 4'b0000);
    cyc(1'b1, 1'b0, 4'b0000, 4'b0000);
    chk++;
    if (a_err !== 4'b0010 || a_ffv !== 1'b1) begin
      fails++;
      $display("FAIL clr_pre err=%b vld=%b exp=0010 vld=1", a_err, a_ffv);
    end
    cyc(1'b1, 1'b0, 4'b0101, 4'b0000);
    cyc(1'b1, 1'b0, 4'b0000, 4'b0000, !use_rst, !use_rst ? 1'b1 : 1'b0);
    chk++;
    if ({a_pass, a_fail, a_err, a_pcnt, a_fcnt, a_ffv, a_ffc} !== 47'h0) begin
      fails++;
      $display("FAIL clr_zero rst=%b err=%b fcnt=%0d vld=%b exp=0", use_rst, a_err, a_fcnt, a_ffv);
    end
    cyc(1'b0, 1'b0, 4'b0000, 4'b0000);
    cyc(1'b0, 1'b0, 4'b0000, 4'b0000);
    chk++;
    if (a_fail !== 4'b0000 || a_fcnt !== 16'd0 || a_err !== 4'b0000) begin
      fails++;
      $display("FAIL clr_after rst=%b fail=%b cnt=%0d exp=0000/0", use_rst, a_fail, a_fcnt);
    end
  endtask

  initial begin
    test_reset();
    test_pass();
    test_fail();
    test_early();
    test_back_to_back();
    test_en();
    test_first_fail();
    test_clear(1'b0);
    test_clear(1'b1);
    $display("TB_RESULT checks=%0d failures=%0d", chk, fails);
    $finish;
  end

endmodule
